// File: rtl/csr_trap_ctrl.sv
// Arbiter/sequencer sharing the machine CSR file's read port and two write ports
// between trap entry, mret and CSR instructions; also drives the PC redirect.
module csr_trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int CSR_AW      = 2,
  parameter int IDX_MSTATUS = 0,
  parameter int IDX_MTVEC   = 1,
  parameter int IDX_MEPC    = 2,
  parameter int IDX_MCAUSE  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trap_valid_in,
  output logic              trap_ready_out,
  input  logic [XLEN-1:0]   trap_pc_in,
  input  logic [XLEN-1:0]   trap_cause_in,
  input  logic              mret_valid_in,
  output logic              mret_ready_out,
  input  logic              inst_valid_in,
  output logic              inst_ready_out,
  input  logic [CSR_AW-1:0] inst_addr_in,
  input  logic              inst_wen_in,
  input  logic [XLEN-1:0]   inst_wdata_in,
  output logic [XLEN-1:0]   inst_rdata_out,
  output logic              inst_rdata_valid_out,
  output logic              csr_wr_en_out,
  output logic [CSR_AW-1:0] csr_wr_addr_out_1,
  output logic [XLEN-1:0]   csr_wr_data_out_1,
  output logic [CSR_AW-1:0] csr_wr_addr_out_2,
  output logic [XLEN-1:0]   csr_wr_data_out_2,
  output logic [CSR_AW-1:0] csr_rd_addr_out,
  input  logic [XLEN-1:0]   csr_rd_data_in,
  output logic              redirect_valid_out,
  output logic [XLEN-1:0]   redirect_pc_out,
  output logic              busy_out
);

  localparam logic [CSR_AW-1:0] A_MTVEC  = CSR_AW'(IDX_MTVEC);
  localparam logic [CSR_AW-1:0] A_MEPC   = CSR_AW'(IDX_MEPC);
  localparam logic [CSR_AW-1:0] A_MCAUSE = CSR_AW'(IDX_MCAUSE);

  // mstatus is never touched here, but its slot must not alias the ones we write.
  if (IDX_MSTATUS == IDX_MTVEC || IDX_MSTATUS == IDX_MEPC || IDX_MSTATUS == IDX_MCAUSE) begin : g_idx_alias
    $error("csr_trap_ctrl: IDX_MSTATUS aliases another CSR index");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRAP_SAVE = 3'd1,
    TRAP_JUMP = 3'd2,
    MRET_JUMP = 3'd3,
    INST_RW   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [CSR_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              wen_q, wen_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    pc_d                 = pc_q;
    cause_d              = cause_q;
    addr_d               = addr_q;
    wdata_d              = wdata_q;
    wen_d                = wen_q;
    trap_ready_out       = 1'b0;
    mret_ready_out       = 1'b0;
    inst_ready_out       = 1'b0;
    inst_rdata_out       = '0;
    inst_rdata_valid_out = 1'b0;
    csr_wr_en_out        = 1'b0;
    csr_wr_addr_out_1    = '0;
    csr_wr_data_out_1    = '0;
    csr_wr_addr_out_2    = '0;
    csr_wr_data_out_2    = '0;
    csr_rd_addr_out      = '0;
    redirect_valid_out   = 1'b0;
    redirect_pc_out      = '0;
    case (state_q)
      IDLE: begin
        trap_ready_out = trap_valid_in;
        mret_ready_out = mret_valid_in & ~trap_valid_in;
        inst_ready_out = inst_valid_in & ~trap_valid_in & ~mret_valid_in;
        if (trap_valid_in) begin
          pc_d    = trap_pc_in;
          cause_d = trap_cause_in;
          state_d = TRAP_SAVE;
        end else if (mret_valid_in) begin
          state_d = MRET_JUMP;
        end else if (inst_valid_in) begin
          addr_d  = inst_addr_in;
          wen_d   = inst_wen_in;
          wdata_d = inst_wdata_in;
          state_d = INST_RW;
        end
      end
      TRAP_SAVE: begin
        csr_wr_en_out     = 1'b1;
        csr_wr_addr_out_1 = A_MEPC;
        csr_wr_data_out_1 = pc_q;
        csr_wr_addr_out_2 = A_MCAUSE;
        csr_wr_data_out_2 = cause_q;
        csr_rd_addr_out   = A_MTVEC;
        state_d           = TRAP_JUMP;
      end
      TRAP_JUMP: begin
        // Direct mode only: the vector's mode bits are dropped from the target.
        csr_rd_addr_out    = A_MTVEC;
        redirect_valid_out = 1'b1;
        redirect_pc_out    = {csr_rd_data_in[XLEN-1:2], 2'b00};
        state_d            = IDLE;
      end
      MRET_JUMP: begin
        csr_rd_addr_out    = A_MEPC;
        redirect_valid_out = 1'b1;
        redirect_pc_out    = csr_rd_data_in;
        state_d            = IDLE;
      end
      INST_RW: begin
        // The read is combinational, so it returns the value before this edge's write.
        csr_rd_addr_out      = addr_q;
        inst_rdata_out       = csr_rd_data_in;
        inst_rdata_valid_out = 1'b1;
        if (wen_q) begin
          csr_wr_en_out     = 1'b1;
          csr_wr_addr_out_1 = addr_q;
          csr_wr_data_out_1 = wdata_q;
          csr_wr_addr_out_2 = addr_q;
          csr_wr_data_out_2 = wdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: a CSR file around the DUT, a transaction-level model
// that schedules expected per-cycle outputs on each accept, directed cases, then random traffic.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_valid_in = 1'b0;
  logic        trap_ready_out;
  logic [31:0] trap_pc_in = '0;
  logic [31:0] trap_cause_in = '0;
  logic        mret_valid_in = 1'b0;
  logic        mret_ready_out;
  logic        inst_valid_in = 1'b0;
  logic        inst_ready_out;
  logic [1:0]  inst_addr_in = '0;
  logic        inst_wen_in = 1'b0;
  logic [31:0] inst_wdata_in = '0;
  logic [31:0] inst_rdata_out;
  logic        inst_rdata_valid_out;
  logic        csr_wr_en_out;
  logic [1:0]  csr_wr_addr_out_1;
  logic [31:0] csr_wr_data_out_1;
  logic [1:0]  csr_wr_addr_out_2;
  logic [31:0] csr_wr_data_out_2;
  logic [1:0]  csr_rd_addr_out;
  logic [31:0] csr_rd_data_in;
  logic        redirect_valid_out;
  logic [31:0] redirect_pc_out;
  logic        busy_out;

  always #5 clk = ~clk;

  csr_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .trap_valid_in(trap_valid_in), .trap_ready_out(trap_ready_out),
    .trap_pc_in(trap_pc_in), .trap_cause_in(trap_cause_in),
    .mret_valid_in(mret_valid_in), .mret_ready_out(mret_ready_out),
    .inst_valid_in(inst_valid_in), .inst_ready_out(inst_ready_out),
    .inst_addr_in(inst_addr_in), .inst_wen_in(inst_wen_in), .inst_wdata_in(inst_wdata_in),
    .inst_rdata_out(inst_rdata_out), .inst_rdata_valid_out(inst_rdata_valid_out),
    .csr_wr_en_out(csr_wr_en_out),
    .csr_wr_addr_out_1(csr_wr_addr_out_1), .csr_wr_data_out_1(csr_wr_data_out_1),
    .csr_wr_addr_out_2(csr_wr_addr_out_2), .csr_wr_data_out_2(csr_wr_data_out_2),
    .csr_rd_addr_out(csr_rd_addr_out), .csr_rd_data_in(csr_rd_data_in),
    .redirect_valid_out(redirect_valid_out), .redirect_pc_out(redirect_pc_out),
    .busy_out(busy_out)
  );

  // CSR file seen by the DUT: combinational read, two write ports (port 2 wins on collision).
  logic [31:0] env_csr [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  assign csr_rd_data_in = env_csr[csr_rd_addr_out];
  always @(posedge clk) begin
    if (csr_wr_en_out) begin
      env_csr[csr_wr_addr_out_1] <= csr_wr_data_out_1;
      env_csr[csr_wr_addr_out_2] <= csr_wr_data_out_2;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  // Expected outputs for one busy cycle.
  typedef struct {
    logic        wr;
    logic [1:0]  a1;
    logic [31:0] d1;
    logic [1:0]  a2;
    logic [31:0] d2;
    logic [1:0]  rd;
    logic        redir;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] rdata;
  } exp_t;

  function automatic exp_t blank();
    exp_t e;
    e.wr = 1'b0; e.a1 = '0; e.d1 = '0; e.a2 = '0; e.d2 = '0;
    e.rd = '0; e.redir = 1'b0; e.rpc = '0; e.rv = 1'b0; e.rdata = '0;
    return e;
  endfunction

  exp_t        exp_q[$];
  logic [31:0] m_csr [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  bit          pend = 1'b0;
  exp_t        pend_e;
  bit          rst_at_edge = 1'b0;
  bit          m_acc_t = 1'b0, m_acc_m = 1'b0, m_acc_i = 1'b0;

  always @(posedge clk) rst_at_edge <= rst_n;

  always @(negedge clk) begin : model_cmp
    exp_t e, e2;
    bit   busy_e, rt, rm, ri;
    cyc++;
    // A write seen last cycle landed only if reset was high at the edge.
    if (pend && rst_at_edge) begin
      m_csr[pend_e.a1] = pend_e.d1;
      m_csr[pend_e.a2] = pend_e.d2;
    end
    pend = 1'b0;
    m_acc_t = 1'b0; m_acc_m = 1'b0; m_acc_i = 1'b0;
    rt = 1'b0; rm = 1'b0; ri = 1'b0;
    e = blank();
    busy_e = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      busy_e = 1'b1;
    end else begin
      rt = trap_valid_in;
      rm = mret_valid_in && !trap_valid_in;
      ri = inst_valid_in && !trap_valid_in && !mret_valid_in;
      m_acc_t = rt; m_acc_m = rm; m_acc_i = ri;
      if (rt) begin
        e2 = blank();
        e2.wr = 1'b1; e2.a1 = 2'd2; e2.d1 = trap_pc_in; e2.a2 = 2'd3; e2.d2 = trap_cause_in;
        e2.rd = 2'd1;
        exp_q.push_back(e2);
        e2 = blank();
        e2.rd = 2'd1; e2.redir = 1'b1; e2.rpc = m_csr[1] & 32'hFFFF_FFFC;
        exp_q.push_back(e2);
      end else if (rm) begin
        e2 = blank();
        e2.rd = 2'd2; e2.redir = 1'b1; e2.rpc = m_csr[2];
        exp_q.push_back(e2);
      end else if (ri) begin
        e2 = blank();
        e2.rd = inst_addr_in; e2.rv = 1'b1; e2.rdata = m_csr[inst_addr_in];
        if (inst_wen_in) begin
          e2.wr = 1'b1; e2.a1 = inst_addr_in; e2.d1 = inst_wdata_in;
          e2.a2 = inst_addr_in; e2.d2 = inst_wdata_in;
        end
        exp_q.push_back(e2);
      end
    end
    chk("trap_ready", 32'(trap_ready_out), 32'(rt));
    chk("mret_ready", 32'(mret_ready_out), 32'(rm));
    chk("inst_ready", 32'(inst_ready_out), 32'(ri));
    chk("busy", 32'(busy_out), 32'(busy_e));
    chk("wr_en", 32'(csr_wr_en_out), 32'(e.wr));
    chk("wr_addr1", 32'(csr_wr_addr_out_1), 32'(e.a1));
    chk("wr_data1", csr_wr_data_out_1, e.d1);
    chk("wr_addr2", 32'(csr_wr_addr_out_2), 32'(e.a2));
    chk("wr_data2", csr_wr_data_out_2, e.d2);
    chk("rd_addr", 32'(csr_rd_addr_out), 32'(e.rd));
    chk("redir_valid", 32'(redirect_valid_out), 32'(e.redir));
    chk("redir_pc", redirect_pc_out, e.rpc);
    chk("rdata_valid", 32'(inst_rdata_valid_out), 32'(e.rv));
    chk("rdata", inst_rdata_out, e.rdata);
    if (e.wr) begin
      pend = 1'b1;
      pend_e = e;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    at_neg();
    chk("L_rst_busy", 32'(busy_out), 32'h0);
    chk("L_rst_redir", 32'(redirect_valid_out), 32'h0);
    chk("L_rst_wr", 32'(csr_wr_en_out), 32'h0);
    chk("L_rst_rv", 32'(inst_rdata_valid_out), 32'h0);
    #2 rst_n = 1'b1;
    tick();

    // Program mtvec through the DUT
    inst_valid_in = 1'b1; inst_addr_in = 2'd1; inst_wen_in = 1'b1; inst_wdata_in = 32'h8000_0100;
    at_neg(); chk("L_init_ready", 32'(inst_ready_out), 32'h1);
    tick(); inst_valid_in = 1'b0;
    tick();

    // 1: trap entry
    trap_valid_in = 1'b1; trap_pc_in = 32'h8000_0010; trap_cause_in = 32'd11;
    at_neg(); chk("L1_ready", 32'(trap_ready_out), 32'h1);
    tick(); trap_valid_in = 1'b0;
    at_neg();
    chk("L1_wr_en", 32'(csr_wr_en_out), 32'h1);
    chk("L1_mepc", csr_wr_data_out_1, 32'h8000_0010);
    chk("L1_mcause", csr_wr_data_out_2, 32'h0000_000B);
    chk("L1_no_redir_yet", 32'(redirect_valid_out), 32'h0);
    tick();
    at_neg();
    chk("L1_redir", 32'(redirect_valid_out), 32'h1);
    chk("L1_redir_pc", redirect_pc_out, 32'h8000_0100);
    tick();
    at_neg();
    chk("L1_file_mepc", env_csr[2], 32'h8000_0010);
    chk("L1_file_mcause", env_csr[3], 32'h0000_000B);
    tick();

    // 2: mret
    mret_valid_in = 1'b1;
    at_neg(); chk("L2_ready", 32'(mret_ready_out), 32'h1);
    tick(); mret_valid_in = 1'b0;
    at_neg();
    chk("L2_redir_pc", redirect_pc_out, 32'h8000_0010);
    chk("L2_no_write", 32'(csr_wr_en_out), 32'h0);
    tick();

    // 3: csr write to mtvec, then trap uses masked vector
    inst_valid_in = 1'b1; inst_addr_in = 2'd1; inst_wen_in = 1'b1; inst_wdata_in = 32'h8000_0203;
    tick(); inst_valid_in = 1'b0;
    at_neg();
    chk("L3_rdata", inst_rdata_out, 32'h8000_0100);
    chk("L3_wr_en", 32'(csr_wr_en_out), 32'h1);
    tick();
    trap_valid_in = 1'b1; trap_pc_in = 32'h8000_0020; trap_cause_in = 32'd2;
    tick(); trap_valid_in = 1'b0;
    tick();
    at_neg(); chk("L3_redir_pc", redirect_pc_out, 32'h8000_0200);
    tick();

    // 4: all three requesters at once
    trap_valid_in = 1'b1; trap_pc_in = 32'h8000_0444; trap_cause_in = 32'd7;
    mret_valid_in = 1'b1;
    inst_valid_in = 1'b1; inst_addr_in = 2'd3; inst_wen_in = 1'b0; inst_wdata_in = 32'hDEAD_BEEF;
    at_neg();
    chk("L4_trap_ready", 32'(trap_ready_out), 32'h1);
    chk("L4_mret_ready", 32'(mret_ready_out), 32'h0);
    chk("L4_inst_ready", 32'(inst_ready_out), 32'h0);
    tick(); trap_valid_in = 1'b0;
    tick();
    tick();
    at_neg();
    chk("L4_mret_ready2", 32'(mret_ready_out), 32'h1);
    chk("L4_inst_ready2", 32'(inst_ready_out), 32'h0);
    tick(); mret_valid_in = 1'b0;
    at_neg(); chk("L4_mret_pc", redirect_pc_out, 32'h8000_0444);
    tick();
    at_neg(); chk("L4_inst_ready3", 32'(inst_ready_out), 32'h1);
    tick(); inst_valid_in = 1'b0;
    at_neg(); chk("L4_rdata", inst_rdata_out, 32'h0000_0007);
    tick();

    // 5: read-only access to mcause
    inst_valid_in = 1'b1; inst_addr_in = 2'd3; inst_wen_in = 1'b0; inst_wdata_in = 32'h1234_5678;
    tick(); inst_valid_in = 1'b0;
    at_neg();
    chk("L5_rv", 32'(inst_rdata_valid_out), 32'h1);
    chk("L5_rdata", inst_rdata_out, 32'h0000_0007);
    chk("L5_no_write", 32'(csr_wr_en_out), 32'h0);
    tick();

    // 6: reset during TRAP_SAVE, before the write edge
    trap_valid_in = 1'b1; trap_pc_in = 32'h8000_0ABC; trap_cause_in = 32'd5;
    tick(); trap_valid_in = 1'b0;
    at_neg();
    rst_n = 1'b0;
    #1;
    chk("L6_wr_en", 32'(csr_wr_en_out), 32'h0);
    chk("L6_busy", 32'(busy_out), 32'h0);
    chk("L6_redir", 32'(redirect_valid_out), 32'h0);
    chk("L6_wr_data1", csr_wr_data_out_1, 32'h0);
    @(posedge clk);
    at_neg();
    chk("L6_mepc_kept", env_csr[2], 32'h8000_0444);
    chk("L6_mcause_kept", env_csr[3], 32'h0000_0007);
    #2 rst_n = 1'b1;
    tick();
    tick();

    // Random traffic; a requester that was not accepted holds valid and fields.
    for (int i = 0; i < 3000; i++) begin
      if (!(trap_valid_in && !m_acc_t)) begin
        trap_valid_in = ($urandom_range(0, 99) < 20);
        trap_pc_in    = $urandom;
        trap_cause_in = $urandom;
      end
      if (!(mret_valid_in && !m_acc_m)) begin
        mret_valid_in = ($urandom_range(0, 99) < 25);
      end
      if (!(inst_valid_in && !m_acc_i)) begin
        inst_valid_in = ($urandom_range(0, 99) < 50);
        inst_addr_in  = 2'($urandom_range(0, 3));
        inst_wen_in   = 1'($urandom_range(0, 1));
        inst_wdata_in = $urandom;
      end
      tick();
    end
    trap_valid_in = 1'b0; mret_valid_in = 1'b0; inst_valid_in = 1'b0;
    repeat (5) tick();
    at_neg();
    chk("L_end_idle", 32'(busy_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
